// File: rtl/param_counter.sv
// Width-generic up/down counter with programmable modulus, parallel load,
// wrap/saturate/one-shot modes, terminal-count pulse and sticky overflow flag.
module param_counter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    input  logic [1:0]       MODE,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF,
    output logic             BUSY
);

    localparam logic [WIDTH-1:0] MAX_Q      = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_Q      = WIDTH'(RST_VAL);
    localparam bit               FULL_RANGE = (MAX_Q == {WIDTH{1'b1}});

    localparam logic [1:0] MODE_SAT = 2'b01;
    localparam logic [1:0] MODE_ONE = 2'b10;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;
    logic             ovf_set;
    logic [WIDTH-1:0] din_clamp;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] wrap_q;
    logic             at_term;
    logic             one_shot;

    // A full-range modulus can never be exceeded by DIN, so skip the compare
    generate
        if (FULL_RANGE) begin : g_full
            assign din_clamp = DIN;
        end else begin : g_clamp
            assign din_clamp = (DIN > MAX_Q) ? MAX_Q : DIN;
        end
    endgenerate

    assign one_shot = (MODE == MODE_ONE);
    assign at_term  = UP ? (Q == MAX_Q) : (Q == '0);
    assign step_q   = UP ? (Q + WIDTH'(1)) : (Q - WIDTH'(1));
    assign wrap_q   = UP ? '0 : MAX_Q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            Q     <= RST_Q;
            TC    <= 1'b0;
            OVF   <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            Q     <= q_nxt;
            TC    <= tc_nxt;
            OVF   <= ovf_nxt;
            BUSY  <= (state_nxt == RUN);
        end
    end

    // Next count / flags; priority LOAD > EN step
    always_comb begin
        state_nxt = state;
        q_nxt     = Q;
        tc_nxt    = 1'b0;
        ovf_set   = 1'b0;

        if (LOAD) begin
            q_nxt     = din_clamp;
            state_nxt = one_shot ? RUN : IDLE;
        end else if (!one_shot) begin
            state_nxt = IDLE;
            if (EN) begin
                if (at_term) begin
                    tc_nxt  = 1'b1;
                    ovf_set = 1'b1;
                    if (MODE != MODE_SAT) begin
                        q_nxt = wrap_q;
                    end
                end else begin
                    q_nxt = step_q;
                end
            end
        end else if (state == RUN && EN) begin
            if (at_term) begin
                tc_nxt    = 1'b1;
                state_nxt = IDLE;
            end else begin
                q_nxt = step_q;
            end
        end

        ovf_nxt = ovf_set | (OVF & ~CLR_OVF);
    end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: two instances (modulus 16 and 10) share stimulus and
// are checked every cycle against an arithmetic reference plus literal spot checks.
module tb_param_counter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic       UP;
    logic       LOAD;
    logic [3:0] DIN;
    logic [1:0] MODE;
    logic       CLR_OVF;

    logic [3:0] q15, q9;
    logic       tc15, tc9, ovf15, ovf9, busy15, busy9;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    param_counter #(.WIDTH(4), .MAX_VAL(15), .RST_VAL(0)) dut15 (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .DIN(DIN),
        .MODE(MODE), .CLR_OVF(CLR_OVF), .Q(q15), .TC(tc15), .OVF(ovf15), .BUSY(busy15)
    );

    param_counter #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) dut9 (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .DIN(DIN),
        .MODE(MODE), .CLR_OVF(CLR_OVF), .Q(q9), .TC(tc9), .OVF(ovf9), .BUSY(busy9)
    );

    // Reference state, index 0 = modulus 16, index 1 = modulus 10
    int m_max [2] = '{15, 9};
    int m_q   [2];
    int m_tc  [2];
    int m_ovf [2];
    int m_run [2];
    bit m_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference: next value by plain arithmetic, boundary when it leaves 0..max
    always @(posedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            int nxt;
            bit osh;
            bit set;
            if (!RST) begin
                m_q[d] = 0; m_tc[d] = 0; m_ovf[d] = 0; m_run[d] = 0;
            end else begin
                osh = (MODE == 2'd2);
                set = 1'b0;
                m_tc[d] = 0;
                nxt = m_q[d] + (UP ? 1 : -1);
                if (LOAD) begin
                    m_q[d]   = (int'(DIN) > m_max[d]) ? m_max[d] : int'(DIN);
                    m_run[d] = osh ? 1 : 0;
                end else if (!osh) begin
                    m_run[d] = 0;
                    if (EN) begin
                        if (nxt < 0 || nxt > m_max[d]) begin
                            m_tc[d] = 1;
                            set = 1'b1;
                            if (MODE != 2'd1)
                                m_q[d] = (nxt + m_max[d] + 1) % (m_max[d] + 1);
                        end else begin
                            m_q[d] = nxt;
                        end
                    end
                end else if (m_run[d] != 0 && EN) begin
                    if (nxt < 0 || nxt > m_max[d]) begin
                        m_tc[d]  = 1;
                        m_run[d] = 0;
                    end else begin
                        m_q[d] = nxt;
                    end
                end
                m_ovf[d] = (set || (m_ovf[d] != 0 && !CLR_OVF)) ? 1 : 0;
            end
        end
        if (!RST) m_valid = 1'b1;
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("q15",    int'(q15),    m_q[0]);
            chk("tc15",   int'(tc15),   m_tc[0]);
            chk("ovf15",  int'(ovf15),  m_ovf[0]);
            chk("busy15", int'(busy15), m_run[0]);
            chk("q9",     int'(q9),     m_q[1]);
            chk("tc9",    int'(tc9),    m_tc[1]);
            chk("ovf9",   int'(ovf9),   m_ovf[1]);
            chk("busy9",  int'(busy9),  m_run[1]);
        end
    end

    // Apply one cycle of inputs, return 1 time unit after the edge
    task automatic cyc(input logic rst, input logic en, input logic up, input logic load,
                       input logic [3:0] din, input logic [1:0] mode, input logic clr);
        RST = rst; EN = en; UP = up; LOAD = load; DIN = din; MODE = mode; CLR_OVF = clr;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset
        cyc(0, 1, 1, 1, 4'd7, 2'd0, 0);
        cyc(0, 0, 1, 0, 4'd0, 2'd0, 0);
        chk("rst_q", int'(q15), 0);
        chk("rst_tc", int'(tc15), 0);
        chk("rst_ovf", int'(ovf15), 0);
        chk("rst_busy", int'(busy15), 0);

        // Wrap up-count through the full modulus
        for (int k = 1; k <= 17; k++) begin
            cyc(1, 1, 1, 0, 4'd0, 2'd0, 0);
            if (k == 15) begin
                chk("t1_q15", int'(q15), 15);
                chk("t1_tc15", int'(tc15), 0);
                chk("t1_ovf15", int'(ovf15), 0);
            end
            if (k == 16) begin
                chk("t1_q16", int'(q15), 0);
                chk("t1_tc16", int'(tc15), 1);
                chk("t1_ovf16", int'(ovf15), 1);
            end
            if (k == 17) begin
                chk("t1_q17", int'(q15), 1);
                chk("t1_tc17", int'(tc15), 0);
                chk("t1_ovf17", int'(ovf15), 1);
            end
        end

        // Wrap down-count, modulus 10, from 0
        cyc(0, 0, 1, 0, 4'd0, 2'd0, 0);
        cyc(1, 1, 0, 0, 4'd0, 2'd0, 0);
        chk("t2_q_a", int'(q9), 9);
        chk("t2_tc_a", int'(tc9), 1);
        chk("t2_ovf_a", int'(ovf9), 1);
        cyc(1, 1, 0, 0, 4'd0, 2'd0, 0);
        chk("t2_q_b", int'(q9), 8);
        chk("t2_tc_b", int'(tc9), 0);
        cyc(1, 1, 0, 0, 4'd0, 2'd0, 0);
        chk("t2_q_c", int'(q9), 7);
        chk("t2_ovf_c", int'(ovf9), 1);

        // Saturate up, clear-vs-set priority
        cyc(1, 0, 1, 1, 4'd14, 2'd1, 1);
        chk("t3_load_q", int'(q15), 14);
        chk("t3_load_ovf", int'(ovf15), 0);
        chk("t3_clamp9", int'(q9), 9);
        cyc(1, 1, 1, 0, 4'd0, 2'd1, 0);
        chk("t3_q1", int'(q15), 15);
        chk("t3_tc1", int'(tc15), 0);
        cyc(1, 1, 1, 0, 4'd0, 2'd1, 0);
        chk("t3_q2", int'(q15), 15);
        chk("t3_tc2", int'(tc15), 1);
        chk("t3_ovf2", int'(ovf15), 1);
        cyc(1, 1, 1, 0, 4'd0, 2'd1, 0);
        chk("t3_tc3", int'(tc15), 1);
        cyc(1, 1, 1, 0, 4'd0, 2'd1, 1);
        chk("t3_q4", int'(q15), 15);
        chk("t3_tc4", int'(tc15), 1);
        chk("t3_setwins", int'(ovf15), 1);
        cyc(1, 0, 1, 0, 4'd0, 2'd1, 1);
        chk("t3_clr", int'(ovf15), 0);
        chk("t3_hold_tc", int'(tc15), 0);

        // One-shot run
        cyc(1, 1, 1, 0, 4'd0, 2'd2, 0);
        chk("t4_idle_q", int'(q15), 15);
        chk("t4_idle_busy", int'(busy15), 0);
        cyc(1, 0, 1, 1, 4'd13, 2'd2, 0);
        chk("t4_load_q", int'(q15), 13);
        chk("t4_load_busy", int'(busy15), 1);
        cyc(1, 1, 1, 0, 4'd0, 2'd2, 0);
        chk("t4_q14", int'(q15), 14);
        cyc(1, 1, 1, 0, 4'd0, 2'd2, 0);
        chk("t4_q15", int'(q15), 15);
        chk("t4_busy15", int'(busy15), 1);
        chk("t4_tc15", int'(tc15), 0);
        cyc(1, 1, 1, 0, 4'd0, 2'd2, 0);
        chk("t4_end_q", int'(q15), 15);
        chk("t4_end_tc", int'(tc15), 1);
        chk("t4_end_busy", int'(busy15), 0);
        cyc(1, 1, 1, 0, 4'd0, 2'd2, 0);
        chk("t4_after_q", int'(q15), 15);
        chk("t4_after_tc", int'(tc15), 0);
        chk("t4_no_ovf", int'(ovf15), 0);

        // Leaving one-shot mid-run drops BUSY and keeps Q
        cyc(1, 0, 1, 1, 4'd5, 2'd2, 0);
        chk("t4_run_busy", int'(busy15), 1);
        cyc(1, 0, 1, 0, 4'd0, 2'd0, 0);
        chk("t4_leave_busy", int'(busy15), 0);
        chk("t4_leave_q", int'(q15), 5);

        // Load clamp and load-over-step priority
        cyc(1, 0, 1, 1, 4'd12, 2'd0, 0);
        chk("t5_clamp", int'(q9), 9);
        chk("t5_noclamp", int'(q15), 12);
        cyc(1, 1, 1, 1, 4'd3, 2'd0, 0);
        chk("t5_load_q", int'(q9), 3);
        chk("t5_load_tc", int'(tc9), 0);

        // Saturate down to 0
        for (int k = 1; k <= 4; k++) begin
            cyc(1, 1, 0, 0, 4'd0, 2'd1, 0);
            if (k == 3) chk("sd_q3", int'(q15), 0);
            if (k == 4) begin
                chk("sd_q4", int'(q15), 0);
                chk("sd_tc4", int'(tc15), 1);
            end
        end

        // Patterned mix of all controls, checked by the reference only
        for (int i = 0; i < 60; i++) begin
            cyc(1, (i % 5) != 0, ((i / 7) % 2) == 0, (i % 11) == 3,
                4'((i * 5) % 16), 2'((i / 9) % 4), (i % 13) == 0);
        end

        // Reset during a one-shot run with LOAD and EN active
        cyc(1, 0, 1, 1, 4'd15, 2'd0, 0);
        cyc(1, 1, 1, 0, 4'd0, 2'd0, 0);
        chk("t6_pre_ovf", int'(ovf15), 1);
        cyc(1, 0, 1, 1, 4'd2, 2'd2, 0);
        chk("t6_pre_busy", int'(busy15), 1);
        cyc(0, 1, 1, 1, 4'd9, 2'd2, 0);
        chk("t6_q", int'(q15), 0);
        chk("t6_tc", int'(tc15), 0);
        chk("t6_ovf", int'(ovf15), 0);
        chk("t6_busy", int'(busy15), 0);

        cyc(1, 0, 1, 0, 4'd0, 2'd0, 0);
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
